// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit with stall and write-back tag.
// Optional MULTDIV_EARLY_ZERO_EN: a multiply with a zero operand completes without iterating.
module multdiv_sequencer #(
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic        flush,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        data_resultRDY,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] rstatus_data
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [4:0]  counter;
  logic [32:0] acc_hi;   // Booth partial product high half / division remainder
  logic [31:0] acc_lo;   // multiplier being shifted out / dividend-in, quotient-out
  logic        q_m1;
  logic [31:0] opnd;     // multiplicand, or divisor magnitude
  logic        neg_quo;
  logic [4:0]  rd_tag;

  logic [32:0] booth_addend, booth_sum, booth_hi_next;
  logic [31:0] booth_lo_next;
  logic [63:0] product;
  logic        mul_ovf;
  logic [32:0] div_shift, div_diff, div_rem_next;
  logic        div_bit;
  logic [31:0] div_quo_next, quotient;
  logic [31:0] abs_a, abs_b;
  logic        div_zero;
  logic [31:0] done_result;
  logic        done_exc;

  always_comb begin
    booth_addend = 33'd0;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_addend = {opnd[31], opnd};
      2'b10:   booth_addend = -{opnd[31], opnd};
      default: booth_addend = 33'd0;
    endcase
    booth_sum     = acc_hi + booth_addend;
    booth_hi_next = {booth_sum[32], booth_sum[32:1]};
    booth_lo_next = {booth_sum[0], acc_lo[31:1]};
    product       = {booth_hi_next[31:0], booth_lo_next};
    // Fits in 32-bit signed only if the top 33 bits are a pure sign extension.
    mul_ovf       = !((&product[63:31]) || (~|product[63:31]));

    div_shift     = {acc_hi[31:0], acc_lo[31]};
    div_diff      = div_shift - {1'b0, opnd};
    div_bit       = ~div_diff[32];
    div_rem_next  = div_bit ? div_diff : div_shift;
    div_quo_next  = {acc_lo[30:0], div_bit};
    quotient      = neg_quo ? -div_quo_next : div_quo_next;
    div_zero      = (opnd == 32'd0);

    abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    done_result = 32'd0;
    done_exc    = 1'b0;
    if (state == MUL) begin
      done_result = product[31:0];
      done_exc    = mul_ovf;
    end else if (state == DIV) begin
      done_result = div_zero ? 32'd0 : quotient;
      done_exc    = div_zero;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      counter        <= 5'd0;
      acc_hi         <= 33'd0;
      acc_lo         <= 32'd0;
      q_m1           <= 1'b0;
      opnd           <= 32'd0;
      neg_quo        <= 1'b0;
      rd_tag         <= 5'd0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      ctrl_writeReg  <= 5'd0;
      rstatus_data   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          data_resultRDY <= 1'b0;
          counter        <= 5'd0;
          acc_hi         <= 33'd0;
          q_m1           <= 1'b0;
          rd_tag         <= rd_in;
          if (!flush && ctrl_MULT) begin
            busy   <= 1'b1;
            acc_lo <= data_operandB;
            opnd   <= data_operandA;
`ifdef MULTDIV_EARLY_ZERO_EN
            if (data_operandA == 32'd0 || data_operandB == 32'd0) begin
              state          <= DONE;
              data_resultRDY <= 1'b1;
              data_result    <= 32'd0;
              data_exception <= 1'b0;
              ctrl_writeReg  <= rd_in;
              rstatus_data   <= 32'd0;
            end else begin
              state <= MUL;
            end
`else
            state <= MUL;
`endif
          end else if (!flush && ctrl_DIV) begin
            state   <= DIV;
            busy    <= 1'b1;
            acc_lo  <= abs_a;
            opnd    <= abs_b;
            neg_quo <= data_operandA[31] ^ data_operandB[31];
          end
        end

        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if ((state == DIV && div_zero) || counter == 5'd31) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= done_result;
            data_exception <= done_exc;
            ctrl_writeReg  <= done_exc ? 5'd30 : rd_tag;
            rstatus_data   <= !done_exc ? 32'd0 :
                              (state == MUL) ? MUL_EXC_CODE : DIV_EXC_CODE;
          end else begin
            counter <= counter + 5'd1;
            if (state == MUL) begin
              acc_hi <= booth_hi_next;
              acc_lo <= booth_lo_next;
              q_m1   <= acc_lo[0];
            end else begin
              acc_hi <= div_rem_next;
              acc_lo <= div_quo_next;
            end
          end
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer: latency, results, exceptions, flush, reset.
// Build with +define+MULTDIV_EARLY_ZERO_EN to exercise the early-zero multiply path.
module tb_multdiv_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, flush = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, data_resultRDY, data_exception;
  logic [31:0] data_result, rstatus_data;
  logic [4:0]  ctrl_writeReg;

  int n_checks = 0;
  int n_fail = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .flush(flush), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .rd_in(rd_in), .busy(busy), .data_resultRDY(data_resultRDY),
    .data_result(data_result), .data_exception(data_exception),
    .ctrl_writeReg(ctrl_writeReg), .rstatus_data(rstatus_data)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Starts an op at edge 0 and watches cycles 1..40. inj_kind: 1 = ctrl_DIV pulse, 2 = flush,
  // both driven during cycle inj_cyc. Returns RDY cycle (0 if none) and whether busy held throughout.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int inj_cyc, input int inj_kind,
                        output int cyc, output logic busy_ok, output logic busy_after);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b; rd_in = rd;
    cyc = 0; busy_ok = 1'b1; busy_after = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
      if (c == inj_cyc && inj_kind == 1) ctrl_DIV = 1'b1;
      if (c == inj_cyc && inj_kind == 2) flush = 1'b1;
      if (c == inj_cyc + 1) busy_after = busy;
      if (!busy && inj_kind != 2) busy_ok = 1'b0;
      if (data_resultRDY) begin
        cyc = c;
        break;
      end
    end
    $display("op mul=%0b div=%0b A=0x%08h B=0x%08h rd=%0d -> rdy_cycle=%0d result=0x%08h exc=%0b wr=%0d rstatus=%0d",
             m, d, a, b, rd, cyc, data_result, data_exception, ctrl_writeReg, rstatus_data);
  endtask

  task automatic expect_op(input string tag, input int cyc, input int exp_cyc, input logic busy_ok,
                           input logic [31:0] res, input logic exc, input logic [4:0] wr,
                           input logic [31:0] rs);
    check_value({tag, "_cycle"}, cyc, exp_cyc);
    check_value({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check_value({tag, "_result"}, data_result, res);
    check_value({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exc});
    check_value({tag, "_wreg"}, {27'd0, ctrl_writeReg}, {27'd0, wr});
    check_value({tag, "_rstatus"}, rstatus_data, rs);
    @(negedge clock);
    check_value({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check_value({tag, "_rdy_off"}, {31'd0, data_resultRDY}, 32'd0);
    check_value({tag, "_held"}, data_result, res);
  endtask

  initial begin
    int cyc;
    logic bok, bafter;

    #1;
    check_value("reset_busy", {31'd0, busy}, 32'd0);
    check_value("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check_value("reset_result", data_result, 32'd0);
    check_value("reset_rstatus", rstatus_data, 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    run_op(1, 0, 32'd7, -32'sd3, 5'd3, 0, 0, cyc, bok, bafter);
    expect_op("mul_7x-3", cyc, 33, bok, 32'hFFFFFFEB, 0, 5'd3, 32'd0);

    run_op(1, 0, 32'h40000000, 32'd4, 5'd9, 0, 0, cyc, bok, bafter);
    expect_op("mul_ovf", cyc, 33, bok, 32'd0, 1, 5'd30, 32'd4);

    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 5'd4, 0, 0, cyc, bok, bafter);
    expect_op("mul_min_x-1", cyc, 33, bok, 32'h80000000, 1, 5'd30, 32'd4);

    run_op(1, 0, 32'h80000000, 32'd1, 5'd5, 0, 0, cyc, bok, bafter);
    expect_op("mul_min_x1", cyc, 33, bok, 32'h80000000, 0, 5'd5, 32'd0);

    run_op(1, 0, 32'h80000000, 32'h80000000, 5'd6, 0, 0, cyc, bok, bafter);
    expect_op("mul_min_xmin", cyc, 33, bok, 32'd0, 1, 5'd30, 32'd4);

    run_op(0, 1, -32'sd17, 32'd5, 5'd7, 0, 0, cyc, bok, bafter);
    expect_op("div_-17/5", cyc, 33, bok, 32'hFFFFFFFD, 0, 5'd7, 32'd0);

    run_op(0, 1, 32'd100, -32'sd7, 5'd8, 0, 0, cyc, bok, bafter);
    expect_op("div_100/-7", cyc, 33, bok, 32'hFFFFFFF2, 0, 5'd8, 32'd0);

    run_op(0, 1, 32'd9, 32'd0, 5'd10, 0, 0, cyc, bok, bafter);
    expect_op("div_by_zero", cyc, 2, bok, 32'd0, 1, 5'd30, 32'd5);

    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0, 0, cyc, bok, bafter);
    expect_op("div_min/-1", cyc, 33, bok, 32'h80000000, 0, 5'd11, 32'd0);

    // A divide start pulsed mid-multiply must be ignored.
    run_op(1, 0, -32'sd5, -32'sd6, 5'd12, 10, 1, cyc, bok, bafter);
    expect_op("mul_ign_div", cyc, 33, bok, 32'd30, 0, 5'd12, 32'd0);

    // Flush during cycle 15 of a divide: idle from cycle 16, no result, outputs held.
    run_op(0, 1, 32'd1000, 32'd3, 5'd13, 15, 2, cyc, bok, bafter);
    check_value("flush_no_rdy", cyc, 0);
    check_value("flush_busy16", {31'd0, bafter}, 32'd0);
    check_value("flush_held_result", data_result, 32'd30);
    check_value("flush_held_wreg", {27'd0, ctrl_writeReg}, 32'd12);

    // Asynchronous reset in cycle 20 of a multiply clears everything immediately.
    run_op(1, 0, 32'd3, 32'd4, 5'd14, 0, 0, cyc, bok, bafter);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd123; data_operandB = 32'd45; rd_in = 5'd15;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    $display("reset asserted mid-multiply: busy=%0b rdy=%0b result=0x%08h", busy, data_resultRDY, data_result);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_result", data_result, 32'd0);
    check_value("rst_exc", {31'd0, data_exception}, 32'd0);
    check_value("rst_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    check_value("rst_rstatus", rstatus_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(1, 1, 32'd6, 32'd2, 5'd16, 0, 0, cyc, bok, bafter);
    expect_op("both_start", cyc, 33, bok, 32'd12, 0, 5'd16, 32'd0);

`ifdef MULTDIV_EARLY_ZERO_EN
    run_op(1, 0, 32'd77, 32'd0, 5'd17, 0, 0, cyc, bok, bafter);
    expect_op("mul_zero_early", cyc, 1, bok, 32'd0, 0, 5'd17, 32'd0);
`else
    run_op(1, 0, 32'd77, 32'd0, 5'd17, 0, 0, cyc, bok, bafter);
    expect_op("mul_zero_full", cyc, 33, bok, 32'd0, 0, 5'd17, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
